bw_resizer: RTL and testbench

Parametrised AXI-Stream lane resizer for the DDC datapath.
- Successor to the fixed 2x48->64 sign-extending expander.
- Splits each beat into N_LANES signed samples. Each sample gets an optional rounding right-shift, then is sign-extended or saturated to OUT_W.
- Output is registered through a full-throughput skid buffer, and saturation events are reported per lane.
- Sits between DDC accumulator/filter outputs and DMA/packing stages.

---
 rtl/bw_resizer.sv | 130 +++++++++++++
 tb/tb_bw_resizer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bw_resizer.sv
// AXI-Stream lane resizer: per-lane rounding shift, then sign-extend or saturate to OUT_W.
// One cycle from acceptance to output; a skid register keeps full throughput, and tready drops only while it is occupied.
module bw_resizer #(
  parameter int N_LANES = 2,
  parameter int IN_W    = 48,
  parameter int OUT_W   = 64,
  parameter int SHIFT   = 0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_LANES*IN_W-1:0]  s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [N_LANES*OUT_W-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic                     sat_clear,
  output logic [N_LANES-1:0]       sat_flag,
  output logic [31:0]              sat_count
);

  localparam int RW = IN_W + 1;
  localparam bit CLAMP = OUT_W < (IN_W - SHIFT + 1);
  localparam logic [RW-1:0] RND = (RW'(1) << SHIFT) >> 1;

  logic [N_LANES*OUT_W-1:0] res;
  logic [N_LANES-1:0]       sat;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic signed [RW-1:0]    ext;
    logic signed [RW-1:0]    r;
    logic signed [OUT_W-1:0] y;
    logic                    s;

    // One guard bit above the sample keeps the rounding add from overflowing.
    assign ext = $signed({s_axis_tdata[k*IN_W + IN_W-1], s_axis_tdata[k*IN_W +: IN_W]}) + $signed(RND);
    assign r   = ext >>> SHIFT;

    if (CLAMP) begin : g_clamp
      localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [RW-1:0] MINV = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      logic s_hi;
      logic s_lo;
      assign s_hi = r > MAXV;
      assign s_lo = r < MINV;
      assign y    = s_hi ? MAXV[OUT_W-1:0] : (s_lo ? MINV[OUT_W-1:0] : r[OUT_W-1:0]);
      assign s    = s_hi | s_lo;
    end else begin : g_ext
      assign y = OUT_W'($signed(r));
      assign s = 1'b0;
    end

    assign res[k*OUT_W +: OUT_W] = y;
    assign sat[k]                = s;
  end

  logic                     or_vld_q, or_vld_d;
  logic [N_LANES*OUT_W-1:0] or_dat_q, or_dat_d;
  logic                     sr_vld_q, sr_vld_d;
  logic [N_LANES*OUT_W-1:0] sr_dat_q, sr_dat_d;
  logic                     rdy_q, rdy_d;
  logic [N_LANES-1:0]       flag_q, flag_d;
  logic [31:0]              cnt_q, cnt_d;
  logic [31:0]              cnt_base;
  logic                     acc;
  logic                     drain;
  logic                     sat_ev;

  assign acc    = s_axis_tvalid & rdy_q;
  assign drain  = or_vld_q & m_axis_tready;
  assign sat_ev = acc & (|sat);

  always_comb begin
    or_vld_d = or_vld_q;
    or_dat_d = or_dat_q;
    sr_vld_d = sr_vld_q;
    sr_dat_d = sr_dat_q;
    if (drain) begin
      if (sr_vld_q) begin
        or_dat_d = sr_dat_q;
        sr_vld_d = 1'b0;
      end else if (acc) begin
        or_dat_d = res;
      end else begin
        or_vld_d = 1'b0;
      end
    end else if (acc) begin
      if (!or_vld_q) begin
        or_vld_d = 1'b1;
        or_dat_d = res;
      end else begin
        sr_vld_d = 1'b1;
        sr_dat_d = res;
      end
    end
    rdy_d = !sr_vld_d;

    // A clear coincident with an event keeps that event.
    flag_d   = (sat_clear ? '0 : flag_q) | (acc ? sat : '0);
    cnt_base = sat_clear ? '0 : cnt_q;
    cnt_d    = (sat_ev && cnt_base != 32'hFFFF_FFFF) ? cnt_base + 32'd1 : cnt_base;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      or_vld_q <= 1'b0;
      or_dat_q <= '0;
      sr_vld_q <= 1'b0;
      sr_dat_q <= '0;
      rdy_q    <= 1'b0;
      flag_q   <= '0;
      cnt_q    <= '0;
    end else begin
      or_vld_q <= or_vld_d;
      or_dat_q <= or_dat_d;
      sr_vld_q <= sr_vld_d;
      sr_dat_q <= sr_dat_d;
      rdy_q    <= rdy_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = or_vld_q;
  assign m_axis_tdata  = or_dat_q;
  assign sat_flag      = flag_q;
  assign sat_count     = cnt_q;

endmodule

// File: tb/tb_bw_resizer.sv
// Bench for bw_resizer: a sign-extending 2x48->64 instance and a rounding/saturating 2x48->16 instance.
module tb_bw_resizer;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic rstn;

  logic [95:0]  a_s_dat;
  logic         a_s_vld, a_s_rdy, a_m_vld, a_m_rdy, a_clr;
  logic [127:0] a_m_dat;
  logic [1:0]   a_flag;
  logic [31:0]  a_cnt;

  logic [95:0]  b_s_dat;
  logic         b_s_vld, b_s_rdy, b_m_vld, b_m_rdy, b_clr;
  logic [31:0]  b_m_dat;
  logic [1:0]   b_flag;
  logic [31:0]  b_cnt;

  bw_resizer u_a (
    .aclk(aclk), .aresetn(rstn),
    .s_axis_tdata(a_s_dat), .s_axis_tvalid(a_s_vld), .s_axis_tready(a_s_rdy),
    .m_axis_tdata(a_m_dat), .m_axis_tvalid(a_m_vld), .m_axis_tready(a_m_rdy),
    .sat_clear(a_clr), .sat_flag(a_flag), .sat_count(a_cnt)
  );

  bw_resizer #(.N_LANES(2), .IN_W(48), .OUT_W(16), .SHIFT(16)) u_b (
    .aclk(aclk), .aresetn(rstn),
    .s_axis_tdata(b_s_dat), .s_axis_tvalid(b_s_vld), .s_axis_tready(b_s_rdy),
    .m_axis_tdata(b_m_dat), .m_axis_tvalid(b_m_vld), .m_axis_tready(b_m_rdy),
    .sat_clear(b_clr), .sat_flag(b_flag), .sat_count(b_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] qa[$];
  logic [31:0]  qb[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_a(input logic [95:0] d);
    logic [127:0] y;
    for (int k = 0; k < 2; k++) y[k*64 +: 64] = {{16{d[k*48+47]}}, d[k*48 +: 48]};
    return y;
  endfunction

  function automatic logic [31:0] exp_b(input logic [95:0] d);
    logic [31:0] y;
    longint x;
    for (int k = 0; k < 2; k++) begin
      x = $signed(d[k*48 +: 48]);
      x = (x + 64'sd32768) >>> 16;
      if (x > 64'sd32767) x = 64'sd32767;
      if (x < -64'sd32768) x = -64'sd32768;
      y[k*16 +: 16] = x[15:0];
    end
    return y;
  endfunction

  function automatic logic [95:0] mk(input int i);
    logic [47:0] v;
    v = 48'(i);
    return {~v, v};
  endfunction

  bit           chk_occ = 1'b0;
  bit           a_stall = 1'b0;
  logic [127:0] a_prev;
  int           a_out = 0;

  always @(negedge aclk) begin
    if (!rstn) begin
      a_stall = 1'b0;
    end else begin
      if (chk_occ) begin
        chk("a_tready_vs_skid", a_s_rdy, qa.size() < 2);
        chk("a_tvalid_vs_occ", a_m_vld, qa.size() > 0);
      end
      if (a_stall) begin
        chk("a_stall_vld", a_m_vld, 1'b1);
        chk("a_stall_dat", a_m_dat, a_prev);
      end
      if (a_s_vld && a_s_rdy) qa.push_back(exp_a(a_s_dat));
      if (a_m_vld && a_m_rdy) begin
        a_out++;
        chk("a_out_expected", qa.size() != 0, 1'b1);
        if (qa.size() != 0) chk("a_out_dat", a_m_dat, qa.pop_front());
      end
      a_stall = a_m_vld && !a_m_rdy;
      a_prev  = a_m_dat;
    end
  end

  always @(negedge aclk) begin
    if (rstn) begin
      if (b_s_vld && b_s_rdy) qb.push_back(exp_b(b_s_dat));
      if (b_m_vld && b_m_rdy) begin
        chk("b_out_expected", qb.size() != 0, 1'b1);
        if (qb.size() != 0) chk("b_out_dat", b_m_dat, qb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, bubbles, out0;
    bit acc;
    rstn = 1'b0;
    a_s_dat = '0; a_s_vld = 1'b0; a_m_rdy = 1'b0; a_clr = 1'b0;
    b_s_dat = '0; b_s_vld = 1'b0; b_m_rdy = 1'b0; b_clr = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_a_vld", a_m_vld, 1'b0);
    chk("rst_a_dat", a_m_dat, 128'd0);
    chk("rst_a_rdy", a_s_rdy, 1'b0);
    chk("rst_a_flag", a_flag, 2'b00);
    chk("rst_b_cnt", b_cnt, 32'd0);
    rstn = 1'b1;
    @(posedge aclk); #1;
    chk("rst_rel_a_rdy", a_s_rdy, 1'b1);
    chk("rst_rel_b_rdy", b_s_rdy, 1'b1);

    // Sign extension with extreme values, one-cycle latency.
    a_m_rdy = 1'b1;
    a_s_dat = {48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000};
    a_s_vld = 1'b1;
    @(posedge aclk); #1;
    a_s_vld = 1'b0;
    chk("t1_vld", a_m_vld, 1'b1);
    chk("t1_dat", a_m_dat, {64'h0000_7FFF_FFFF_FFFF, 64'hFFFF_8000_0000_0000});
    chk("t1_flag", a_flag, 2'b00);

    // Rounding without saturation.
    b_m_rdy = 1'b1;
    b_s_dat = {48'hFFFF_FFFF_7FFF, 48'h0000_0001_8000};
    b_s_vld = 1'b1;
    @(posedge aclk); #1;
    b_s_vld = 1'b0;
    chk("t2_vld", b_m_vld, 1'b1);
    chk("t2_dat", b_m_dat, 32'hFFFF_0002);
    chk("t2_flag", b_flag, 2'b00);
    chk("t2_cnt", b_cnt, 32'd0);

    // Saturation both directions.
    b_s_dat = {48'h8000_0000_0000, 48'h7FFF_8000_0000};
    b_s_vld = 1'b1;
    @(posedge aclk); #1;
    b_s_vld = 1'b0;
    chk("t3_dat", b_m_dat, 32'h8000_7FFF);
    chk("t3_flag", b_flag, 2'b11);
    chk("t3_cnt", b_cnt, 32'd1);

    // Clear coincident with a lane-0 event.
    b_s_dat = {48'h0, 48'h7FFF_8000_0000};
    b_s_vld = 1'b1; b_clr = 1'b1;
    @(posedge aclk); #1;
    b_s_vld = 1'b0; b_clr = 1'b0;
    chk("t3c_flag", b_flag, 2'b01);
    chk("t3c_cnt", b_cnt, 32'd1);

    b_s_dat = {48'h8000_0000_0000, 48'h0000_0000_0000};
    b_s_vld = 1'b1;
    @(posedge aclk); #1;
    b_s_vld = 1'b0;
    chk("t3d_flag", b_flag, 2'b11);
    chk("t3d_cnt", b_cnt, 32'd2);

    b_clr = 1'b1;
    @(posedge aclk); #1;
    b_clr = 1'b0;
    chk("t3e_flag", b_flag, 2'b00);
    chk("t3e_cnt", b_cnt, 32'd0);

    b_s_dat = {48'h8000_0000_0000, 48'h7FFF_8000_0000};
    b_s_vld = 1'b1;
    @(posedge aclk); #1;
    b_s_vld = 1'b0;
    chk("t3f_cnt", b_cnt, 32'd1);

    // Random backpressure, 100 incrementing beats.
    sent = 0; acc = 1'b0; out0 = a_out;
    chk_occ = 1'b1;
    for (int g = 0; g < 5000 && sent < 100; g++) begin
      if (acc) begin sent++; a_s_vld = 1'b0; end
      if (sent < 100 && !a_s_vld) a_s_vld = 1'($urandom_range(0, 1));
      a_s_dat = mk(sent);
      a_m_rdy = 1'($urandom_range(0, 1));
      @(negedge aclk);
      acc = a_s_vld && a_s_rdy;
      @(posedge aclk); #1;
    end
    a_s_vld = 1'b0;
    a_m_rdy = 1'b1;
    for (int g = 0; g < 200 && qa.size() != 0; g++) @(posedge aclk);
    #1;
    chk_occ = 1'b0;
    chk("t4_sent", sent, 100);
    chk("t4_drained", qa.size(), 0);
    chk("t4_outs", a_out - out0, 100);

    // Continuous streaming, no bubbles.
    bubbles = 0; out0 = a_out;
    for (int i = 0; i < 1000; i++) begin
      a_s_dat = mk(i + 1000);
      a_s_vld = 1'b1;
      @(negedge aclk);
      if (i > 0 && !a_m_vld) bubbles++;
      if (!a_s_rdy) bubbles++;
      @(posedge aclk); #1;
    end
    a_s_vld = 1'b0;
    for (int g = 0; g < 20 && qa.size() != 0; g++) @(posedge aclk);
    #1;
    chk("t5_bubbles", bubbles, 0);
    chk("t5_outs", a_out - out0, 1000);

    // Reset with output and skid registers both full.
    a_m_rdy = 1'b0;
    a_s_dat = mk(5); a_s_vld = 1'b1;
    b_s_dat = {48'h8000_0000_0000, 48'h7FFF_8000_0000}; b_s_vld = 1'b1;
    @(posedge aclk); #1;
    b_s_vld = 1'b0;
    a_s_dat = mk(6);
    @(posedge aclk); #1;
    a_s_vld = 1'b0;
    chk("t6_skid_full_rdy", a_s_rdy, 1'b0);
    chk("t6_b_cnt_pre", b_cnt, 32'd2);
    rstn = 1'b0;
    qa.delete(); qb.delete();
    @(posedge aclk); #1;
    chk("t6_vld", a_m_vld, 1'b0);
    chk("t6_b_cnt", b_cnt, 32'd0);
    chk("t6_rdy_in_rst", a_s_rdy, 1'b0);
    rstn = 1'b1;
    @(posedge aclk); #1;
    chk("t6_rdy_after", a_s_rdy, 1'b1);
    chk("t6_vld_after", a_m_vld, 1'b0);
    a_m_rdy = 1'b1;
    a_s_dat = mk(7); a_s_vld = 1'b1;
    @(posedge aclk); #1;
    a_s_vld = 1'b0;
    chk("t6_new_vld", a_m_vld, 1'b1);
    chk("t6_new_dat", a_m_dat, exp_a(mk(7)));
    repeat (3) @(posedge aclk);
    #1;
    chk("t6_drained", qa.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
